// File: rtl/dbg_pkg.sv
// Shared debug-dump constants: latch widths, word counts, frame layout and FSM states.
// Frame length depends on the DUMP_CHECKSUM_EN build macro.
package dbg_pkg;

  localparam int unsigned IF_ID_W  = 64;
  localparam int unsigned ID_EX_W  = 139;
  localparam int unsigned EX_MEM_W = 76;
  localparam int unsigned MEM_WB_W = 71;
  localparam int unsigned SNAP_W   = IF_ID_W + ID_EX_W + EX_MEM_W + MEM_WB_W;

  localparam int unsigned IF_ID_LSB  = 0;
  localparam int unsigned ID_EX_LSB  = IF_ID_LSB + IF_ID_W;
  localparam int unsigned EX_MEM_LSB = ID_EX_LSB + ID_EX_W;
  localparam int unsigned MEM_WB_LSB = EX_MEM_LSB + EX_MEM_W;

  localparam int unsigned IF_ID_WORDS  = (IF_ID_W + 31) / 32;
  localparam int unsigned ID_EX_WORDS  = (ID_EX_W + 31) / 32;
  localparam int unsigned EX_MEM_WORDS = (EX_MEM_W + 31) / 32;
  localparam int unsigned MEM_WB_WORDS = (MEM_WB_W + 31) / 32;
  localparam int unsigned DATA_WORDS   = IF_ID_WORDS + ID_EX_WORDS + EX_MEM_WORDS + MEM_WB_WORDS;
  localparam int unsigned PAD_W        = DATA_WORDS * 32;

  localparam logic [15:0] HEADER_TAG_DEFAULT = 16'hA5A5;

`ifdef DUMP_CHECKSUM_EN
  localparam int unsigned PAYLOAD_WORDS = DATA_WORDS + 1;
`else
  localparam int unsigned PAYLOAD_WORDS = DATA_WORDS;
`endif
  localparam int unsigned FRAME_WORDS = PAYLOAD_WORDS + 1;

  localparam int unsigned          IDX_W         = 4;
  localparam logic [IDX_W-1:0]     LAST_DATA_IDX = IDX_W'(DATA_WORDS);
  localparam logic [IDX_W-1:0]     LAST_IDX      = IDX_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StSend, StDone} dump_state_e;

endpackage

// File: rtl/dump_word_mux.sv
// Maps (snapshot, word index, checksum) to the 32-bit frame word; zero when not enabled.
module dump_word_mux
  import dbg_pkg::*;
#(
  parameter logic [15:0] HeaderTag = HEADER_TAG_DEFAULT
) (
  input  logic              en_i,
  input  logic [SNAP_W-1:0] snap_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [31:0]       csum_i,
  output logic [31:0]       data_o
);

  logic [PAD_W-1:0] padded;
  logic [IDX_W-1:0] pidx;

  // Each field zero-extended to whole words, laid out LSB-first in frame order.
  assign padded = {
    {(MEM_WB_WORDS * 32 - MEM_WB_W){1'b0}}, snap_i[MEM_WB_LSB +: MEM_WB_W],
    {(EX_MEM_WORDS * 32 - EX_MEM_W){1'b0}}, snap_i[EX_MEM_LSB +: EX_MEM_W],
    {(ID_EX_WORDS * 32 - ID_EX_W){1'b0}},   snap_i[ID_EX_LSB +: ID_EX_W],
    snap_i[IF_ID_LSB +: IF_ID_W]
  };

  always_comb begin
    data_o = '0;
    pidx   = idx_i - 1'b1;
    if (en_i) begin
      if (idx_i == '0) begin
        data_o = {HeaderTag, 8'h00, 8'(PAYLOAD_WORDS)};
      end else if (idx_i <= LAST_DATA_IDX) begin
        data_o = padded[{pidx, 5'b0} +: 32];
      end else begin
        data_o = csum_i;
      end
    end
  end

endmodule

// File: rtl/latch_dump_serializer.sv
// Snapshots the four pipeline latches on request and streams them as a framed word
// sequence into the TX FIFO. Build macro DUMP_CHECKSUM_EN appends an XOR checksum word.
module latch_dump_serializer
  import dbg_pkg::*;
#(
  parameter int unsigned WORD_BITS  = 32,
  parameter logic [15:0] HEADER_TAG = HEADER_TAG_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [IF_ID_W-1:0]   i_IF_ID_latch,
  input  logic [ID_EX_W-1:0]   i_ID_EX_latch,
  input  logic [EX_MEM_W-1:0]  i_EX_MEM_latch,
  input  logic [MEM_WB_W-1:0]  i_MEM_WB_latch,
  input  logic                 i_fifo_full,
  output logic [WORD_BITS-1:0] o_data,
  output logic                 o_write_en,
  output logic                 o_busy,
  output logic                 o_done
);

  dump_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic [31:0]       csum_word;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    o_write_en = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          snap_d  = {i_MEM_WB_latch, i_EX_MEM_latch, i_ID_EX_latch, i_IF_ID_latch};
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        o_busy     = 1'b1;
        o_write_en = !i_fifo_full;
        if (o_write_en) begin
          if (idx_q == LAST_IDX) state_d = StDone;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      StDone: begin
        o_done  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

`ifdef DUMP_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  // Accumulates every word actually written, excluding the checksum word itself.
  always_comb begin
    csum_d = csum_q;
    if (state_q == StIdle && i_start) begin
      csum_d = '0;
    end else if (o_write_en && idx_q != LAST_IDX) begin
      csum_d = csum_q ^ o_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) csum_q <= '0;
    else         csum_q <= csum_d;
  end

  assign csum_word = csum_q;
`else
  assign csum_word = '0;
`endif

  dump_word_mux #(
    .HeaderTag (HEADER_TAG)
  ) u_word_mux (
    .en_i   (state_q == StSend),
    .snap_i (snap_q),
    .idx_i  (idx_q),
    .csum_i (csum_word),
    .data_o (o_data)
  );

endmodule

// File: tb/tb_latch_dump_serializer.sv
// Directed self-checking bench for latch_dump_serializer (honours DUMP_CHECKSUM_EN).
module tb_latch_dump_serializer;

`ifdef DUMP_CHECKSUM_EN
  localparam int          FRAME = 15;
  localparam logic [31:0] HDR   = 32'hA5A5000E;
`else
  localparam int          FRAME = 14;
  localparam logic [31:0] HDR   = 32'hA5A5000D;
`endif

  logic         clk = 1'b0;
  logic         rst, start, full;
  logic [63:0]  if_id;
  logic [138:0] id_ex;
  logic [75:0]  ex_mem;
  logic [70:0]  mem_wb;
  logic [31:0]  data;
  logic         we, busy, done;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] got[$];
  logic [31:0] exp_w[15];
  int          done_cyc;

  always #5 clk = ~clk;

  latch_dump_serializer dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_start        (start),
    .i_IF_ID_latch  (if_id),
    .i_ID_EX_latch  (id_ex),
    .i_EX_MEM_latch (ex_mem),
    .i_MEM_WB_latch (mem_wb),
    .i_fifo_full    (full),
    .o_data         (data),
    .o_write_en     (we),
    .o_busy         (busy),
    .o_done         (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_clear();
    for (int i = 0; i < 15; i++) exp_w[i] = 32'h0;
    exp_w[0] = HDR;
  endtask

  task automatic exp_finish();
`ifdef DUMP_CHECKSUM_EN
    exp_w[14] = 32'h0;
    for (int i = 0; i < 14; i++) exp_w[14] ^= exp_w[i];
`endif
  endtask

  task automatic set_basic();
    if_id = 64'h1111_2222_3333_4444; id_ex = '0; ex_mem = '0; mem_wb = '0;
    exp_clear();
    exp_w[1] = 32'h33334444; exp_w[2] = 32'h11112222;
    exp_finish();
  endtask

  task automatic set_ones();
    if_id = 64'h1111_2222_3333_4444; id_ex = '1; ex_mem = '1; mem_wb = '1;
    exp_clear();
    exp_w[1] = 32'h33334444; exp_w[2] = 32'h11112222;
    for (int i = 3; i <= 6; i++) exp_w[i] = 32'hFFFFFFFF;
    exp_w[7]  = 32'h000007FF;
    exp_w[8]  = 32'hFFFFFFFF; exp_w[9]  = 32'hFFFFFFFF; exp_w[10] = 32'h00000FFF;
    exp_w[11] = 32'hFFFFFFFF; exp_w[12] = 32'hFFFFFFFF; exp_w[13] = 32'h0000007F;
    exp_finish();
  endtask

  task automatic set_pattern();
    if_id  = 64'h1111_2222_3333_4444;
    id_ex  = {11'h5A3, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    ex_mem = {12'hABC, 32'h66666666, 32'h55555555};
    mem_wb = {7'h55, 32'h88888888, 32'h77777777};
    exp_clear();
    exp_w[1]  = 32'h33334444; exp_w[2]  = 32'h11112222;
    exp_w[3]  = 32'h11111111; exp_w[4]  = 32'h22222222; exp_w[5]  = 32'h33333333;
    exp_w[6]  = 32'h44444444; exp_w[7]  = 32'h000005A3;
    exp_w[8]  = 32'h55555555; exp_w[9]  = 32'h66666666; exp_w[10] = 32'h00000ABC;
    exp_w[11] = 32'h77777777; exp_w[12] = 32'h88888888; exp_w[13] = 32'h00000055;
    exp_finish();
  endtask

  // Pulses start, then collects writes until o_done (bounded at 40 cycles).
  task automatic run_frame(input int stall_at, input int stall_len, input bit mutate);
    int stalled = 0;
    got.delete();
    done_cyc = -1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) step();
      if (mutate && c == 1) begin
        if_id = ~if_id; id_ex = ~id_ex; ex_mem = ~ex_mem; mem_wb = ~mem_wb;
      end
      if (mutate) start = (c == 6);
      full = (got.size() == stall_at) && (stalled < stall_len);
      #1;
      if (full) begin
        check_eq("stall_we", {31'b0, we}, 32'h0);
        check_eq("stall_data", data, exp_w[stall_at]);
        stalled++;
      end
      if (we) got.push_back(data);
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    full  = 1'b0;
    start = 1'b0;
    if (done_cyc < 0) check_eq("done_timeout", 32'h0, 32'h1);
  endtask

  task automatic check_frame(input string tag, input int exp_done);
    check_eq({tag, "_len"}, 32'(got.size()), 32'(FRAME));
    for (int i = 0; i < FRAME; i++) begin
      check_eq($sformatf("%s_w%0d", tag, i), (i < got.size()) ? got[i] : 32'hDEADBEEF,
               exp_w[i]);
    end
    check_eq({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
    step();
    check_eq({tag, "_done_pulse"}, {31'b0, done}, 32'h0);
    check_eq({tag, "_busy_after"}, {31'b0, busy}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; full = 1'b0;
    if_id = '0; id_ex = '0; ex_mem = '0; mem_wb = '0;
    repeat (3) step();
    check_eq("rst_we", {31'b0, we}, 32'h0);
    check_eq("rst_busy", {31'b0, busy}, 32'h0);
    check_eq("rst_done", {31'b0, done}, 32'h0);
    check_eq("rst_data", data, 32'h0);
    rst = 1'b0;
    step();

    set_basic();
    run_frame(-1, 0, 1'b0);
    check_frame("basic", FRAME + 1);

    set_ones();
    run_frame(-1, 0, 1'b0);
    check_frame("ones", FRAME + 1);

    set_pattern();
    run_frame(4, 5, 1'b0);
    check_frame("stall", FRAME + 6);

    // Latches flip after the start edge and a second start arrives mid-frame.
    set_ones();
    run_frame(-1, 0, 1'b1);
    check_frame("atomic", FRAME + 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("atomic_no_restart", {31'b0, we}, 32'h0);
    end

    set_basic();
    got.delete();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 30 && got.size() < 7; c++) begin
      if (c > 0) step();
      #1;
      if (we) got.push_back(data);
    end
    check_eq("abort_pre_words", 32'(got.size()), 32'd7);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_eq("abort_we", {31'b0, we}, 32'h0);
    check_eq("abort_busy", {31'b0, busy}, 32'h0);
    check_eq("abort_data", data, 32'h0);
    run_frame(-1, 0, 1'b0);
    check_frame("after_abort", FRAME + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
